// File: rtl/i2c_master_byte_ctrl_pkg.sv
// Shared definitions for the I2C byte controller: bit-controller command
// encodings and the byte-level sequencer states.
package i2c_master_byte_ctrl_pkg;

  // Bit-controller command encodings (one-hot, NOP = all zero)
  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

  // Byte-controller sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } byte_state_e;

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// I2C master byte controller: turns one byte-level request (optional START,
// WRITE or READ of 8 bits plus the ack bit, optional STOP) into a series of
// single-bit commands for the bit controller, and returns the received byte
// and acknowledge.
//
// Handshakes:
//   * Request side: start/stop/read/write are held by the requester until
//     cmd_ack. cmd_ack is a one-cycle completion pulse and masks go for that
//     cycle, so a request still asserted then is not restarted.
//   * Bit-controller side: core_cmd is held stable until core_ack pulses;
//     the next command (or NOP) is registered on the core_ack cycle.
module i2c_master_byte_ctrl
  import i2c_master_byte_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       nReset,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd
);

  byte_state_e state_q;
  logic [7:0]  sr_q;
  logic [2:0]  cnt_q;
  logic        cmd_ack_q;
  logic        ack_out_q;
  logic [3:0]  core_cmd_q;
  logic        core_txd_q;
  logic        go;

  // A new request starts only when not in the completion-pulse cycle
  assign go = (start | stop | read | write) & ~cmd_ack_q;

  // Byte sequencer: state, shift register, bit counter and all outputs
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= ST_IDLE;
      sr_q       <= 8'h00;
      cnt_q      <= 3'd0;
      cmd_ack_q  <= 1'b0;
      ack_out_q  <= 1'b0;
      core_cmd_q <= I2C_CMD_NOP;
      core_txd_q <= 1'b0;
    end else begin
      cmd_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            sr_q  <= din;
            cnt_q <= 3'd7;
            if (start) begin
              state_q    <= ST_START;
              core_cmd_q <= I2C_CMD_START;
            end else if (read) begin
              state_q    <= ST_READ;
              core_cmd_q <= I2C_CMD_READ;
            end else if (write) begin
              state_q    <= ST_WRITE;
              core_cmd_q <= I2C_CMD_WRITE;
              core_txd_q <= din[7];
            end else begin
              state_q    <= ST_STOP;
              core_cmd_q <= I2C_CMD_STOP;
            end
          end
        end

        ST_START: begin
          if (core_ack) begin
            if (read) begin
              state_q    <= ST_READ;
              core_cmd_q <= I2C_CMD_READ;
            end else if (write) begin
              state_q    <= ST_WRITE;
              core_cmd_q <= I2C_CMD_WRITE;
              core_txd_q <= sr_q[7];
            end else if (stop) begin
              state_q    <= ST_STOP;
              core_cmd_q <= I2C_CMD_STOP;
            end else begin
              state_q    <= ST_IDLE;
              core_cmd_q <= I2C_CMD_NOP;
              cmd_ack_q  <= 1'b1;
            end
          end
        end

        ST_WRITE, ST_READ: begin
          if (core_ack) begin
            // Received bits shift in at the bottom; transmit bits come from the top
            sr_q <= {sr_q[6:0], core_rxd};
            if (cnt_q != 3'd0) begin
              cnt_q      <= cnt_q - 3'd1;
              core_txd_q <= sr_q[6];
            end else begin
              state_q <= ST_ACK;
              if (state_q == ST_WRITE) begin
                // Release the bus and sample the slave's acknowledge
                core_cmd_q <= I2C_CMD_READ;
              end else begin
                // Master drives its own ACK/NACK after a read
                core_cmd_q <= I2C_CMD_WRITE;
                core_txd_q <= ack_in;
              end
            end
          end
        end

        ST_ACK: begin
          if (core_ack) begin
            ack_out_q <= core_rxd;
            if (stop) begin
              state_q    <= ST_STOP;
              core_cmd_q <= I2C_CMD_STOP;
            end else begin
              state_q    <= ST_IDLE;
              core_cmd_q <= I2C_CMD_NOP;
              cmd_ack_q  <= 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (core_ack) begin
            state_q    <= ST_IDLE;
            core_cmd_q <= I2C_CMD_NOP;
            cmd_ack_q  <= 1'b1;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          core_cmd_q <= I2C_CMD_NOP;
        end
      endcase
    end
  end

  assign cmd_ack  = cmd_ack_q;
  assign ack_out  = ack_out_q;
  assign dout     = sr_q;
  assign core_cmd = core_cmd_q;
  assign core_txd = core_txd_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: a table of byte-level requests is run
// against a scripted bit-controller model, followed by hand-written
// sequences for request hold-over, idle acks and mid-transfer reset.
module tb_i2c_master_byte_ctrl;

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  logic       start, stop, read, write, ack_in;
  logic [7:0] din;
  logic       cmd_ack, ack_out;
  logic [7:0] dout;
  logic [3:0] core_cmd;
  logic       core_txd;
  logic       core_ack, core_rxd;

  i2c_master_byte_ctrl dut (
    .clk      (clk),
    .nReset   (nReset),
    .start    (start),
    .stop     (stop),
    .read     (read),
    .write    (write),
    .ack_in   (ack_in),
    .din      (din),
    .cmd_ack  (cmd_ack),
    .ack_out  (ack_out),
    .dout     (dout),
    .core_cmd (core_cmd),
    .core_txd (core_txd),
    .core_ack (core_ack),
    .core_rxd (core_rxd)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic       stop;
    logic       rd;
    logic       wr;
    logic       ack_in;
    logic [7:0] din;
    logic [7:0] rx_bits;   // bits returned by the model, MSB first
    logic       ack_rxd;   // bit returned in the ack slot
    logic [7:0] exp_dout;
    logic       exp_ack;
    int         exp_ncmd;
  } vec_t;

  vec_t vecs[7];

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drop_req();
    start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0; ack_in = 1'b0; din = 8'h00;
  endtask

  // ---------------- driver / bit-controller model ----------------
  task automatic pulse_ack(input int dly, input logic r);
    repeat (dly) @(negedge clk);
    core_ack = 1'b1;
    core_rxd = r;
    @(negedge clk);
    core_ack = 1'b0;
    core_rxd = 1'b0;
  endtask

  // Runs one request. Entry {cmd[3:0], txd, txd_care, rxd}.
  // hold = number of cycles after the cmd_ack cycle the request stays asserted.
  task automatic run_req(input vec_t v, input int hold, input string tag);
    logic [6:0] exp_q[$];
    logic [6:0] e;
    int  n_cmd;
    bit  done;
    int  dly;
    exp_q = {};
    if (v.start) exp_q.push_back({CMD_START, 3'b000});
    if (v.rd || v.wr) begin
      for (int i = 7; i >= 0; i--)
        exp_q.push_back({(v.wr ? CMD_WRITE : CMD_READ), v.din[i], v.wr, v.rx_bits[i]});
      if (v.wr) exp_q.push_back({CMD_READ, 1'b0, 1'b0, v.ack_rxd});
      else      exp_q.push_back({CMD_WRITE, v.ack_in, 1'b1, v.ack_rxd});
    end
    if (v.stop) exp_q.push_back({CMD_STOP, 3'b000});

    start = v.start; stop = v.stop; read = v.rd; write = v.wr;
    ack_in = v.ack_in; din = v.din;
    @(negedge clk);
    check({tag, " go_latency"}, 32'(core_cmd != CMD_NOP), 32'd1);

    n_cmd = 0;
    done  = 1'b0;
    for (int g = 0; g < 16 && !done; g++) begin
      if (cmd_ack) begin
        done = 1'b1;
      end else begin
        n_cmd++;
        if (exp_q.size() == 0) e = 7'd0;
        else e = exp_q.pop_front();
        check({tag, " cmd"}, 32'(core_cmd), 32'(e[6:3]));
        if (e[1]) check({tag, " txd"}, 32'(core_txd), 32'(e[2]));
        dly = $urandom_range(4, 20);
        repeat (dly - 1) @(negedge clk);
        check({tag, " cmd_stable"}, 32'(core_cmd), 32'(e[6:3]));
        pulse_ack(0, e[0]);
      end
    end
    check({tag, " cmd_ack_seen"}, 32'(done), 32'd1);
    check({tag, " n_cmd"}, 32'(n_cmd), 32'(v.exp_ncmd));
    check({tag, " exp_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, " nop_at_ack"}, 32'(core_cmd), 32'(CMD_NOP));
    check({tag, " dout"}, 32'(dout), 32'(v.exp_dout));
    check({tag, " ack_out"}, 32'(ack_out), 32'(v.exp_ack));
    if (hold == 0) drop_req();
    @(negedge clk);
    check({tag, " cmd_ack_width"}, 32'(cmd_ack), 32'd0);
    if (hold == 1) drop_req();
    if (hold >= 2) begin
      @(negedge clk);
      drop_req();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    //            start stop  rd    wr    ackin din    rx     ackrx exp_dout exp_ack ncmd
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h96, 1'b0, 8'h96, 1'b0, 10};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'hCA, 1'b1, 8'hCA, 1'b1, 10};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b1, 9};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, 8'h5A, 1'b1, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h81, 1'b0, 8'h81, 1'b0, 11};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 8'h00, 1'b0, 8'h77, 1'b0, 1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hE1, 8'h00, 1'b0, 8'hE1, 1'b0, 2};

    nReset   = 1'b0;
    core_ack = 1'b0;
    core_rxd = 1'b0;
    drop_req();
    repeat (2) @(negedge clk);
    check("rst core_cmd", 32'(core_cmd), 32'(CMD_NOP));
    check("rst cmd_ack",  32'(cmd_ack),  32'd0);
    check("rst ack_out",  32'(ack_out),  32'd0);
    check("rst dout",     32'(dout),     32'h00);
    check("rst core_txd", 32'(core_txd), 32'd0);
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 7; k++) run_req(vecs[k], 0, $sformatf("vec%0d", k));

    // Request held one cycle past cmd_ack: must not restart
    begin
      vec_t h1;
      h1 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 8'h11, 1'b0, 1};
      run_req(h1, 1, "hold1");
      for (int i = 0; i < 6; i++) begin
        check("hold1 no_restart", 32'(core_cmd), 32'(CMD_NOP));
        @(negedge clk);
      end
    end

    // Request held two cycles past cmd_ack: a new START is issued
    begin
      vec_t h2;
      h2 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 8'h22, 1'b0, 1};
      run_req(h2, 2, "hold2");
      check("hold2 restart", 32'(core_cmd), 32'(CMD_START));
      pulse_ack(5, 1'b0);
      check("hold2 restart cmd_ack", 32'(cmd_ack), 32'd1);
      check("hold2 restart nop", 32'(core_cmd), 32'(CMD_NOP));
      check("hold2 restart dout", 32'(dout), 32'h22);
      @(negedge clk);
    end

    // core_ack while idle is ignored
    pulse_ack(2, 1'b1);
    check("idle_ack core_cmd", 32'(core_cmd), 32'(CMD_NOP));
    check("idle_ack cmd_ack",  32'(cmd_ack),  32'd0);
    check("idle_ack ack_out",  32'(ack_out),  32'd0);

    // Reset in the middle of a write, after the third WRITE ack
    start = 1'b1; write = 1'b1; din = 8'hF0;
    @(negedge clk);
    check("rstmid start", 32'(core_cmd), 32'(CMD_START));
    pulse_ack(5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("rstmid write", 32'(core_cmd), 32'(CMD_WRITE));
      pulse_ack(5, 1'b1);
    end
    check("rstmid dout_before", 32'(dout), 32'h87);
    nReset = 1'b0;
    drop_req();
    #1;
    check("rstmid core_cmd", 32'(core_cmd), 32'(CMD_NOP));
    check("rstmid cmd_ack",  32'(cmd_ack),  32'd0);
    check("rstmid ack_out",  32'(ack_out),  32'd0);
    check("rstmid dout",     32'(dout),     32'h00);
    check("rstmid core_txd", 32'(core_txd), 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst idle", 32'(core_cmd), 32'(CMD_NOP));
    end
    begin
      vec_t pr;
      pr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00, 1'b0, 8'h33, 1'b0, 1};
      run_req(pr, 0, "post_rst");
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_ctrl.md
# i2c_master_byte_ctrl

Byte-level sequencer for the I2C master bit controller. Accepts one byte-level request (optional START, one WRITE or READ of 8 bits plus the acknowledge bit, optional STOP) from the register/WISHBONE layer. Breaks the request into single-bit commands on the bit controller's `cmd`/`cmd_ack` interface and returns the received byte and acknowledge. It sits in the I2C master top between the register block and the bit controller.

## Interface
Parameters: none. Command encodings come from the shared defines.

Ports:
- `clk`  in  1  system clock; the only clock.
- `nReset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  generate (repeated) START before the byte.
- `stop`  in  1  generate STOP after the byte.
- `read`  in  1  read one byte.
- `write`  in  1  write one byte.
- `ack_in`  in  1  acknowledge bit the master drives after a read (0 = ACK, 1 = NACK).
- `din`  in  8  byte to transmit, MSB first.
- `cmd_ack`  out  1  one-cycle pulse: request complete.
- `ack_out`  out  1  acknowledge bit sampled during the ack slot.
- `dout`  out  8  received byte.
- `core_cmd`  out  4  command to the bit controller.
- `core_txd`  out  1  bit-controller `din`.
- `core_ack`  in  1  bit-controller `cmd_ack` pulse.
- `core_rxd`  in  1  bit-controller `dout`.

## Operation
- `go` = (`start` | `stop` | `read` | `write`) & !`cmd_ack`.
- Request inputs are held by the requester until `cmd_ack`. `read` and `write` are never both set.
- Internal registers: 8-bit shift register `sr`, 3-bit bit counter `cnt`.
- All outputs are registered.
- State machine states: `ST_IDLE`, `ST_START`, `ST_WRITE`, `ST_READ`, `ST_ACK`, `ST_STOP`.
  - `ST_IDLE` on `go`: load `sr` = `din`, `cnt` = 7, then take the first matching branch.
    - `start` → `ST_START`, `core_cmd` = START.
    - else `read` → `ST_READ`, `core_cmd` = READ.
    - else `write` → `ST_WRITE`, `core_cmd` = WRITE, `core_txd` = `din[7]`.
    - else → `ST_STOP`, `core_cmd` = STOP.
  - `ST_START` on `core_ack`: `read` → `ST_READ`. Otherwise, if `write` → `ST_WRITE` with `core_txd` = `sr[7]`. If neither, go to `ST_STOP` when `stop` is set, else to `ST_IDLE` with `cmd_ack`.
  - `ST_WRITE`/`ST_READ` on `core_ack`:
    - Always: `sr` ← {`sr[6:0]`, `core_rxd`}.
    - If `cnt` ≠ 0: `cnt` decrements, same command reissued, `core_txd` = `sr[6]`.
    - If `cnt` = 0: → `ST_ACK`. After a write, `core_cmd` = READ (sample slave ack). After a read, `core_cmd` = WRITE with `core_txd` = `ack_in`.
  - `ST_ACK` on `core_ack`: `ack_out` ← `core_rxd`. If `stop` → `ST_STOP` with `core_cmd` = STOP; else → `ST_IDLE` with `cmd_ack` pulse.
  - `ST_STOP` on `core_ack`: → `ST_IDLE` with `cmd_ack` pulse.
- `core_cmd` returns to NOP on every `core_ack` cycle that enters `ST_IDLE`. It is held stable between acks.
- `dout` = `sr`. After a read, `dout` is valid from the `cmd_ack` cycle. After a write, `dout` holds don't-care shifted data.
- A `core_ack` arriving in `ST_IDLE` is ignored.
- Reset values: state `ST_IDLE`, `cmd_ack` 0, `ack_out` 0, `dout` 8'h00, `core_cmd` NOP, `core_txd` 0, `cnt` 0.
- Reset mid-operation: all registers return to reset values immediately. The bit controller is reset by the same `nReset`, so no command is left outstanding.

## Timing
- `go` → first `core_cmd` registered: 1 cycle.
- Each `core_ack` → next `core_cmd`: 1 cycle.
- Final `core_ack` → `cmd_ack`: 1 cycle. `cmd_ack` lasts exactly 1 cycle.
- `cmd_ack` masks `go`. A request still asserted in the `cmd_ack` cycle is not restarted. A request still asserted one cycle later starts a new transfer.
- Bit commands per request: 9, plus 1 if `start` is set, plus 1 if `stop` is set. Bus timing is owned entirely by the bit controller.

## Structure
- Command encodings live in the shared `i2c_master_defines.v`, reused, not redefined:
  - `I2C_CMD_NOP` = 4'b0000
  - `I2C_CMD_START` = 4'b0001
  - `I2C_CMD_STOP` = 4'b0010
  - `I2C_CMD_WRITE` = 4'b0100
  - `I2C_CMD_READ` = 4'b1000
- Byte-controller state constants are local parameters.
- No sub-module. The bit controller is instantiated beside this block in the top, not inside it.

## Test plan
All scenarios use a bit-controller model that pulses `core_ack` 4–20 cycles after each non-NOP command and drives a scripted `core_rxd`.
1. `start`=1, `write`=1, `din`=8'hA5, model `core_rxd`=0 on the ack slot → `core_cmd` sequence START, 8×WRITE with `core_txd` 1,0,1,0,0,1,0,1, then READ, NOP. One `cmd_ack` pulse; `ack_out`=0.
2. `read`=1, `ack_in`=1, `stop`=1, model bits 1,1,0,0,1,0,1,0 → 8×READ, WRITE with `core_txd`=1, STOP. `dout`=8'hCA on `cmd_ack`.
3. `write`=1, `din`=8'h00, slave NACK (`core_rxd`=1 on ack) → `ack_out`=1, no STOP issued.
4. `stop` alone → single STOP command, `cmd_ack` one cycle after its `core_ack`.
5. Request held 1 cycle past `cmd_ack` → no restart. Held 2 cycles → new START issued.
6. `nReset` asserted after the 3rd WRITE ack → outputs at reset values in the same cycle, `core_cmd`=NOP. After release, idle until `go`.
